multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main control FSM of the multicycle MIPS datapath; directly upstream of alu_control_unit.
//  Decodes the 6-bit opcode over FETCH/DECODE/EXEC/MEM/WB states and drives datapath selects,
//  memory/register strobes and the 2-bit alu_op consumed by alu_control_unit.
//  Moore outputs from a registered state, except FETCH strobes gated by mem_ready.
// PARAMETERS
//  STATE_W  4  width of state register and of dbg_state port
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  synchronous, active-high
//  opcode         in   6  instr[31:26] from IR; sampled only in DECODE
//  mem_ready      in   1  memory handshake: access completes in a cycle where it is 1
//  pc_write       out  1  PC load enable
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  i_or_d         out  1  memory addr select: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load enable
//  mem_to_reg     out  1  reg write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1  dest reg: 0=rt, 1=rd
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0=PC, 1=A
//  alu_src_b      out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_source      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_op         out  2  to alu_control_unit: 00=add, 01=sub, 10=use funct
//  illegal_op     out  1  high during DECODE when opcode unsupported
//  dbg_state      out  STATE_W  current state code
// BEHAVIOUR
//  States: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC, 7 R_WB,
//          8 BRANCH, 9 JUMP, 10 ADDI_EXEC, 11 ADDI_WB; codes 12-15 unused -> next FETCH.
//  Reset: at the edge with reset=1, state<=FETCH (dominates every transition, mid-op included).
//   Post-reset outputs = FETCH row. All outputs not listed in a state's row are 0.
//  FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready.
//   mem_ready=0 -> hold FETCH (no IR/PC update); mem_ready=1 -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode: 100011 lw / 101011 sw -> MEM_ADDR;
//   000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> see CONFIGURATION;
//   other -> illegal_op=1 (this cycle only), next FETCH, no state/PC/reg write.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEM_RD, sw -> MEM_WR. Opcode held in an
//   internal reg latched in DECODE; MEM_ADDR ignores opcode changes after DECODE.
//  MEM_RD: mem_read=1, i_or_d=1; hold while mem_ready=0; -> MEM_WB when 1.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; hold while mem_ready=0; -> FETCH when 1.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.  R_WB: reg_dst=1, reg_write=1; -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH.
//  JUMP: pc_write=1, pc_source=10; -> FETCH.
//  ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDI_WB. ADDI_WB: reg_write=1; -> FETCH.
//  mem_ready ignored outside FETCH/MEM_RD/MEM_WR. Cycles at mem_ready=1: lw 5, sw 4, R 4, beq 3, j 3, addi 4.
// CONFIGURATION
//  MCU_ADDI_EN defined: opcode 001000 in DECODE -> ADDI_EXEC -> ADDI_WB -> FETCH.
//  Not defined: 001000 is illegal (illegal_op=1, -> FETCH); states 10/11 absent, codes -> FETCH.
// TESTING
//  lw 100011, mem_ready=1: dbg_state 0,1,2,3,4,0; MEM_WB reg_write=1,mem_to_reg=1; MEM_RD i_or_d=1.
//  FETCH, mem_ready=0 for 2 cycles then 1: state stays 0 for 3 cycles, ir_write/pc_write=0,0,1.
//  R-type 000000: states 0,1,6,7,0; R_EXEC alu_op=10; R_WB reg_dst=1,reg_write=1.
//  beq 000100: states 0,1,8,0; BRANCH alu_op=01,pc_write_cond=1,pc_source=01. j: 0,1,9,0,pc_source=10.
//  opcode 111111: DECODE illegal_op=1, next 0; reset=1 in MEM_RD -> next 0, mem_read=1,i_or_d=0.
//  opcode 001000: with MCU_ADDI_EN states 0,1,10,11,0; without, illegal_op=1 and next 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// ============================================================================
// multicycle_control_unit_if : opcode/handshake inputs and datapath controls
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : main control FSM of the multicycle MIPS datapath
// Optional addi support via macro MCU_ADDI_EN.   Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  multicycle_control_unit_if.master   bus,
  output logic [STATE_W-1:0]          dbg_state
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCU_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH     = STATE_W'(0),
    DECODE    = STATE_W'(1),
    MEM_ADDR  = STATE_W'(2),
    MEM_RD    = STATE_W'(3),
    MEM_WB    = STATE_W'(4),
    MEM_WR    = STATE_W'(5),
    R_EXEC    = STATE_W'(6),
    R_WB      = STATE_W'(7),
    BRANCH    = STATE_W'(8),
`ifdef MCU_ADDI_EN
    JUMP      = STATE_W'(9),
    ADDI_EXEC = STATE_W'(10),
    ADDI_WB   = STATE_W'(11)
`else
    JUMP      = STATE_W'(9)
`endif
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        op_q <= bus.opcode;
    end
  end

  assign dbg_state = state_q;

  always_comb begin
    state_d           = FETCH;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC only update in the cycle the instruction read completes
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MCU_ADDI_EN
          OP_ADDI:      state_d = ADDI_EXEC;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        // Only lw/sw reach here, so the latched opcode picks the direction
        state_d       = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_d      = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        state_d       = bus.mem_ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = R_WB;
      end
      R_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_d           = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = FETCH;
      end
`ifdef MCU_ADDI_EN
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : directed checks of the multicycle control FSM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    // post-reset FETCH row, memory not ready
    check("rst_state", dbg_state, 0);
    check("rst_mem_read", bus.mem_read, 1);
    check("rst_alu_src_b", bus.alu_src_b, 2'b01);
    check("rst_ir_write", bus.ir_write, 0);
    check("rst_pc_write", bus.pc_write, 0);
    check("rst_reg_write", bus.reg_write, 0);
    step();
    check("hold1_state", dbg_state, 0);
    check("hold1_ir_write", bus.ir_write, 0);
    step();
    check("hold2_state", dbg_state, 0);
    check("hold2_pc_write", bus.pc_write, 0);
    bus.mem_ready = 1'b1;
    #1;
    check("ready_state", dbg_state, 0);
    check("ready_ir_write", bus.ir_write, 1);
    check("ready_pc_write", bus.pc_write, 1);

    // lw, with opcode changed after DECODE
    step();
    check("lw_dec_state", dbg_state, 1);
    check("lw_dec_alu_src_b", bus.alu_src_b, 2'b11);
    check("lw_dec_illegal", bus.illegal_op, 0);
    step();
    bus.opcode = 6'b101011;
    check("lw_addr_state", dbg_state, 2);
    check("lw_addr_alu_src_a", bus.alu_src_a, 1);
    check("lw_addr_alu_src_b", bus.alu_src_b, 2'b10);
    bus.mem_ready = 1'b0;
    step();
    check("lw_rd_state", dbg_state, 3);
    check("lw_rd_mem_read", bus.mem_read, 1);
    check("lw_rd_i_or_d", bus.i_or_d, 1);
    step();
    check("lw_rd_hold_state", dbg_state, 3);
    bus.mem_ready = 1'b1;
    step();
    check("lw_wb_state", dbg_state, 4);
    check("lw_wb_reg_write", bus.reg_write, 1);
    check("lw_wb_mem_to_reg", bus.mem_to_reg, 1);
    check("lw_wb_reg_dst", bus.reg_dst, 0);
    step();
    check("lw_end_state", dbg_state, 0);

    // R-type
    bus.opcode = 6'b000000;
    step();
    check("r_dec_state", dbg_state, 1);
    step();
    check("r_exec_state", dbg_state, 6);
    check("r_exec_alu_op", bus.alu_op, 2'b10);
    check("r_exec_alu_src_b", bus.alu_src_b, 2'b00);
    step();
    check("r_wb_state", dbg_state, 7);
    check("r_wb_reg_dst", bus.reg_dst, 1);
    check("r_wb_reg_write", bus.reg_write, 1);
    step();
    check("r_end_state", dbg_state, 0);

    // beq
    bus.opcode = 6'b000100;
    step();
    step();
    check("beq_state", dbg_state, 8);
    check("beq_alu_op", bus.alu_op, 2'b01);
    check("beq_pc_write_cond", bus.pc_write_cond, 1);
    check("beq_pc_source", bus.pc_source, 2'b01);
    check("beq_pc_write", bus.pc_write, 0);
    step();
    check("beq_end_state", dbg_state, 0);

    // j
    bus.opcode = 6'b000010;
    step();
    step();
    check("j_state", dbg_state, 9);
    check("j_pc_write", bus.pc_write, 1);
    check("j_pc_source", bus.pc_source, 2'b10);
    step();
    check("j_end_state", dbg_state, 0);

    // sw
    bus.opcode = 6'b101011;
    step();
    step();
    check("sw_addr_state", dbg_state, 2);
    step();
    check("sw_wr_state", dbg_state, 5);
    check("sw_wr_mem_write", bus.mem_write, 1);
    check("sw_wr_i_or_d", bus.i_or_d, 1);
    check("sw_wr_mem_read", bus.mem_read, 0);
    step();
    check("sw_end_state", dbg_state, 0);

    // illegal opcode
    bus.opcode = 6'b111111;
    step();
    check("ill_dec_state", dbg_state, 1);
    check("ill_illegal_op", bus.illegal_op, 1);
    step();
    check("ill_end_state", dbg_state, 0);
    check("ill_fetch_illegal_op", bus.illegal_op, 0);

    // addi
    bus.opcode = 6'b001000;
    step();
    check("addi_dec_state", dbg_state, 1);
`ifdef MCU_ADDI_EN
    check("addi_dec_illegal", bus.illegal_op, 0);
    step();
    check("addi_exec_state", dbg_state, 10);
    check("addi_exec_alu_src_b", bus.alu_src_b, 2'b10);
    check("addi_exec_alu_src_a", bus.alu_src_a, 1);
    step();
    check("addi_wb_state", dbg_state, 11);
    check("addi_wb_reg_write", bus.reg_write, 1);
    check("addi_wb_reg_dst", bus.reg_dst, 0);
    step();
    check("addi_end_state", dbg_state, 0);
`else
    check("addi_dec_illegal", bus.illegal_op, 1);
    step();
    check("addi_end_state", dbg_state, 0);
`endif

    // reset asserted mid-operation in MEM_RD
    bus.opcode = 6'b100011;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    check("mid_rd_state", dbg_state, 3);
    reset = 1'b1;
    step();
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_mem_read", bus.mem_read, 1);
    check("mid_rst_i_or_d", bus.i_or_d, 0);
    reset = 1'b0;
    step();
    check("mid_rst_hold_state", dbg_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
